otter_trap_ctrl: RTL and testbench
==================================

OTTER_TRAP_CTRL -- requirements
Module: otter_trap_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have port instr_valid, input, 1: the current instruction is committing this cycle.
REQ-004 SHALL have port trap, input, 1: misaligned-target exception from the trap generator; qualified by instr_valid.
REQ-005 SHALL have port pc, input, 32: PC of the committing instruction.
REQ-006 SHALL have port bad_addr, input, 32: faulting target address.
REQ-007 SHALL have port ext_irq, input, 1: level-sensitive external interrupt.
REQ-008 SHALL have port mret, input, 1: the committing instruction is MRET.
REQ-009 SHALL have port csr_we, input, 1: CSR write strobe.
REQ-010 SHALL have port csr_addr, input, 12: CSR address.
REQ-011 SHALL have port csr_wdata, input, 32: CSR write data.
REQ-012 SHALL have port csr_rdata, output, 32: combinational CSR read data.
REQ-013 SHALL have port flush, output, 1: kill in-flight pipeline state.
REQ-014 SHALL have port redirect, output, 1: one-cycle PC-load pulse.
REQ-015 SHALL have port redirect_pc, output, 32: PC target, valid while redirect=1.
REQ-016 SHALL have port busy, output, 1: the block is not in IDLE; the pipeline stalls fetch.

Function
REQ-017 SHALL implement these CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, all other bits read 0), mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343; unmapped addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-018 SHALL force mtvec[1:0]=0 and mepc[1:0]=0 on every write (direct mode only).
REQ-019 SHALL use the FSM states IDLE, FLUSH, REDIRECT.
REQ-020 SHALL evaluate the accept condition in IDLE only, with priority trap > irq > mret > csr_we, where trap means trap&instr_valid, irq means ext_irq&MIE&instr_valid&!trap, and mret means mret&instr_valid&!trap.
REQ-021 SHALL, on trap accept in cycle N, capture mepc=pc, mcause=0x00000000, mtval=bad_addr, MPIE=MIE, MIE=0 at the end of N.
REQ-022 SHALL, on irq accept, capture mepc=pc, mcause=0x8000000B, mtval=0, MPIE=MIE, MIE=0.
REQ-023 SHALL, on mret accept, capture MIE=MPIE, MPIE=1, and latch the return target = mepc.
REQ-024 SHALL be in FLUSH with flush=1, busy=1 in cycle N+1, and in REDIRECT with redirect=1, busy=1 in cycle N+2, with redirect_pc = mtvec (trap/irq) or the latched mepc (mret); SHALL return to IDLE in N+3.
REQ-025 SHALL drop a CSR write coincident with an accepted trap/irq/mret; the write SHALL take no effect.
REQ-026 SHALL ignore all of trap, ext_irq, mret and csr_we while busy=1.
REQ-027 SHALL drive flush=0 and redirect=0 in IDLE; a CSR write in IDLE SHALL update the register at the end of the cycle with no stall.
REQ-028 SHALL drive csr_rdata from current register values, not bypassing a same-cycle write.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=IDLE, flush=0, redirect=0, busy=0, redirect_pc=0, and mtvec, mepc, mcause, mtval, MIE, MPIE all to 0.
REQ-030 SHALL, when reset asserts in FLUSH or REDIRECT, abort the sequence and suppress the redirect pulse; after release the FSM SHALL start in IDLE.

Configuration
REQ-031 SHALL, with OTTER_TRAP_MTVAL_EN defined, implement mtval as a 32-bit register per REQ-021/022.
REQ-032 SHALL, without OTTER_TRAP_MTVAL_EN, instantiate no mtval register: address 0x343 SHALL read 0, writes to it SHALL be ignored, and bad_addr SHALL be unused.

Verification
REQ-033 SHALL cover: mtvec=0x100, MIE=1, trap with pc=0x40 and bad_addr=0x4A -> mepc=0x40, mcause=0, mtval=0x4A (0 if macro undefined), MIE=0, MPIE=1; flush in N+1; redirect with redirect_pc=0x100 in N+2.
REQ-034 SHALL cover: MIE=1, ext_irq and trap in the same cycle -> mcause=0 (trap wins); with MIE=0, ext_irq alone -> no flush, no redirect.
REQ-035 SHALL cover: after a trap, mret with mepc=0x40 -> redirect_pc=0x40 in N+2, MIE=1, MPIE=1.
REQ-036 SHALL cover: csr_we to mepc with wdata 0x123 -> read back 0x120; csr_we coincident with a trap -> target CSR unchanged.
REQ-037 SHALL cover: rst_n pulled low during FLUSH -> no redirect pulse and all CSRs read 0; trap asserted while busy -> ignored.

Source files
------------

// File: rtl/otter_trap_ctrl.sv
// otter_trap_ctrl: machine-mode trap/interrupt/mret sequencer with a small CSR file.
// Optional macro OTTER_TRAP_MTVAL_EN adds the mtval register.
module otter_trap_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic        trap,
  input  logic [31:0] pc,
  input  logic [31:0] bad_addr,
  input  logic        ext_irq,
  input  logic        mret,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t state, state_nx;
  logic        mie, mpie;
  logic [31:0] mtvec, mepc, mcause, tgt;
  logic        idle, is_trap, is_irq, is_mret, take, wr;
`ifdef OTTER_TRAP_MTVAL_EN
  logic [31:0] mtval;
`else
  logic        unused_bad_addr;
  assign unused_bad_addr = ^bad_addr;
`endif
  assign idle    = state == IDLE;
  assign is_trap = idle & instr_valid & trap;
  assign is_irq  = idle & instr_valid & ext_irq & mie & !trap;
  assign is_mret = idle & instr_valid & mret & !trap;
  assign take    = is_trap | is_irq | is_mret;
  assign wr      = idle & csr_we & !take;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx    = take ? FLUSH : (state == FLUSH) ? REDIRECT : IDLE;
    flush       = state == FLUSH;
    redirect    = state == REDIRECT;
    busy        = !idle;
    redirect_pc = redirect ? tgt : 32'h0;
  end
  // the redirect target is frozen at accept time, so later CSR state cannot disturb it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mie    <= 1'b0;
      mpie   <= 1'b0;
      mtvec  <= '0;
      mepc   <= '0;
      mcause <= '0;
      tgt    <= '0;
`ifdef OTTER_TRAP_MTVAL_EN
      mtval  <= '0;
`endif
    end else if (is_trap | is_irq) begin
      mepc   <= pc;
      mcause <= is_trap ? 32'h0 : 32'h8000_000B;
      mpie   <= mie;
      mie    <= 1'b0;
      tgt    <= mtvec;
`ifdef OTTER_TRAP_MTVAL_EN
      mtval  <= is_trap ? bad_addr : 32'h0;
`endif
    end else if (is_mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
      tgt  <= mepc;
    end else if (wr) begin
      case (csr_addr)
        12'h300: begin
          mie  <= csr_wdata[3];
          mpie <= csr_wdata[7];
        end
        12'h305: mtvec  <= {csr_wdata[31:2], 2'b00};
        12'h341: mepc   <= {csr_wdata[31:2], 2'b00};
        12'h342: mcause <= csr_wdata;
`ifdef OTTER_TRAP_MTVAL_EN
        12'h343: mtval  <= csr_wdata;
`endif
        default: ;
      endcase
    end
  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h300: csr_rdata = {24'h0, mpie, 3'b000, mie, 3'b000};
      12'h305: csr_rdata = mtvec;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
`ifdef OTTER_TRAP_MTVAL_EN
      12'h343: csr_rdata = mtval;
`endif
      default: csr_rdata = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_otter_trap_ctrl.sv
// tb_otter_trap_ctrl: scoreboard bench; expected redirect targets are queued at accept and checked on redirect.
module tb_otter_trap_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        instr_valid = 0, trap = 0, ext_irq = 0, mret = 0, csr_we = 0;
  logic [31:0] pc = 0, bad_addr = 0, csr_wdata = 0;
  logic [11:0] csr_addr = 0;
  logic [31:0] csr_rdata, redirect_pc;
  logic        flush, redirect, busy;
  int          passed = 0, total = 0;
  logic [31:0] q[$];
`ifdef OTTER_TRAP_MTVAL_EN
  localparam bit MTVAL = 1;
`else
  localparam bit MTVAL = 0;
`endif
  otter_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .trap(trap), .pc(pc),
    .bad_addr(bad_addr), .ext_irq(ext_irq), .mret(mret), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge clk)
    if (redirect) begin
      if (q.size() != 0) check("redirect_pc", redirect_pc, q.pop_front());
      else check("spurious_redirect", 32'(redirect), 32'h0);
    end
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1 check(tag, csr_rdata, exp);
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_we = 0;
  endtask
  task automatic drop();
    instr_valid = 0; trap = 0; ext_irq = 0; mret = 0; csr_we = 0;
  endtask
  task automatic fire(input logic t, input logic i, input logic m, input logic [31:0] p,
                      input logic [31:0] ba, input logic [31:0] exp_tgt, input logic seq);
    @(negedge clk);
    instr_valid = 1; trap = t; ext_irq = i; mret = m; pc = p; bad_addr = ba;
    if (seq) q.push_back(exp_tgt);
    @(negedge clk);
    drop();
    check("flush", 32'(flush), 32'(seq));
    check("busy", 32'(busy), 32'(seq));
    @(negedge clk);
    check("redirect", 32'(redirect), 32'(seq));
    @(negedge clk);
    check("back_idle", 32'(busy), 32'h0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_flush", 32'(flush), 0);
    check("rst_redirect", 32'(redirect), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rpc", redirect_pc, 0);
    rd("rst_mtvec", 12'h305, 0);
    rst_n = 1;
    wr(12'h305, 32'h101);
    rd("mtvec_align", 12'h305, 32'h100);
    wr(12'h300, 32'hFFFF_FFFF);
    rd("mstatus_mask", 12'h300, 32'h88);
    wr(12'h300, 32'h8);
    rd("mstatus_mie", 12'h300, 32'h8);
    fire(1, 0, 0, 32'h40, 32'h4A, 32'h100, 1);
    rd("trap_mepc", 12'h341, 32'h40);
    rd("trap_mcause", 12'h342, 32'h0);
    rd("trap_mtval", 12'h343, MTVAL ? 32'h4A : 32'h0);
    rd("trap_mstatus", 12'h300, 32'h80);
    fire(0, 0, 1, 32'h10, 0, 32'h40, 1);
    rd("mret_mstatus", 12'h300, 32'h88);
    fire(1, 1, 0, 32'h80, 32'h99, 32'h100, 1);
    rd("both_mcause", 12'h342, 32'h0);
    rd("both_mepc", 12'h341, 32'h80);
    fire(0, 1, 0, 32'h84, 0, 0, 0);
    rd("masked_mepc", 12'h341, 32'h80);
    fire(0, 0, 1, 32'h88, 0, 32'h80, 1);
    fire(0, 1, 0, 32'h44, 32'h55, 32'h100, 1);
    rd("irq_mcause", 12'h342, 32'h8000_000B);
    rd("irq_mepc", 12'h341, 32'h44);
    rd("irq_mtval", 12'h343, 32'h0);
    wr(12'h341, 32'h123);
    rd("mepc_align", 12'h341, 32'h120);
    wr(12'h344, 32'hDEAD);
    rd("unmapped", 12'h344, 32'h0);
    @(negedge clk);
    instr_valid = 1; trap = 1; pc = 32'h60; bad_addr = 32'h6;
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h200;
    q.push_back(32'h100);
    @(negedge clk);
    check("busy_flush", 32'(flush), 1);
    pc = 32'h998; csr_wdata = 32'h300;
    @(negedge clk);
    check("busy_redirect", 32'(redirect), 1);
    drop();
    @(negedge clk);
    rd("coincident_mtvec", 12'h305, 32'h100);
    rd("busy_mepc", 12'h341, 32'h60);
    @(negedge clk);
    check("no_retrap", 32'(busy), 0);
    @(negedge clk);
    instr_valid = 1; trap = 1; pc = 32'h70;
    @(negedge clk);
    drop();
    check("pre_rst_flush", 32'(flush), 1);
    rst_n = 0;
    #1 check("arst_flush", 32'(flush), 0);
    check("arst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rd("arst_mstatus", 12'h300, 0);
    rd("arst_mtvec", 12'h305, 0);
    rd("arst_mepc", 12'h341, 0);
    rd("arst_mcause", 12'h342, 0);
    rd("arst_mtval", 12'h343, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("queue_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
